// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32I core:
// sequencer states, trap causes, base opcodes and opcode classifiers.
package core_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } seq_state_t;

  typedef enum logic [1:0] {
    TC_NONE     = 2'd0,
    TC_ILLEGAL  = 2'd1,
    TC_MISALIGN = 2'd2,
    TC_TIMEOUT  = 2'd3
  } trap_cause_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic is_legal_op(input logic [6:0] op);
    logic ok;
    unique case (op)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
      OP_JALR, OP_OP, OP_OPIMM, OP_LUI,
      OP_AUIPC, OP_SYSTEM, OP_FENCE: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus request watchdog shared by the fetch and data phases.
// Ports: clk, rst_n, start (clear), req, ack in; timeout out.
module bus_watchdog #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  localparam int CW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit EN = (MEM_TIMEOUT != 0);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // r_count holds the stalled cycles before this one, so the
  // limit is reached in the cycle that would make it MEM_TIMEOUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (start) begin
      r_count <= '0;
    end else if (EN && req && !ack) begin
      r_count <= r_count + 1'b1;
    end
  end

  // A same-cycle ack suppresses the timeout.
  assign timeout = EN && req && !ack && (r_count == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns pc, runs the
// imem/dmem req/ack handshakes, latches instruction, gates RF/DM writes,
// counts retired instructions and raises a sticky trap with its cause.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        dmem_req,
  input  logic        dmem_ack,
  input  logic        RF_wen,
  input  logic        DM_wen,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        RF_wen_q,
  output logic        DM_wen_q,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] instret,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  seq_state_t  r_state, w_next;
  trap_cause_t r_cause, w_cause;
  logic [31:0] r_pc, r_instr, r_instret;
  logic        w_misalign, w_retire;
  logic        w_start, w_timeout, w_ack;

  assign w_misalign = branch_taken &&
                      (branch_target[1:0] != 2'b00);
  assign w_retire   = (r_state == S_WB) && !w_misalign;
  assign w_ack      = (r_state == S_FETCH) ? imem_ack : dmem_ack;

  // Clear the watchdog on the edge that enters a bus phase.
  assign w_start = (w_next != r_state) &&
                   ((w_next == S_FETCH) || (w_next == S_MEM));

  bus_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_start),
    .req    (imem_req || dmem_req),
    .ack    (w_ack),
    .timeout(w_timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_cause   <= TC_NONE;
      r_pc      <= RESET_PC;
      r_instr   <= NOP;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause;
      if ((r_state == S_FETCH) && imem_ack) begin
        r_instr <= imem_rdata;
      end
      if (w_retire) begin
        r_pc      <= branch_taken ? branch_target
                                  : r_pc + 32'd4;
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_cause = r_cause;
    unique case (r_state)
      S_FETCH: begin
        if (imem_ack) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next  = S_TRAP;
          w_cause = TC_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (is_legal_op(r_instr[6:0])) begin
          w_next = S_EXEC;
        end else begin
          w_next  = S_TRAP;
          w_cause = TC_ILLEGAL;
        end
      end
      S_EXEC: begin
        w_next = is_mem_op(r_instr[6:0]) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_ack) begin
          w_next = S_WB;
        end else if (w_timeout) begin
          w_next  = S_TRAP;
          w_cause = TC_TIMEOUT;
        end
      end
      S_WB: begin
        if (w_misalign) begin
          w_next  = S_TRAP;
          w_cause = TC_MISALIGN;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  // Requests and write strobes drop in the reset cycle itself.
  assign imem_req    = rst_n && (r_state == S_FETCH);
  assign dmem_req    = rst_n && (r_state == S_MEM);
  assign retire      = rst_n && w_retire;
  assign DM_wen_q    = dmem_req && DM_wen;
  assign RF_wen_q    = retire && RF_wen;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign instret     = r_instret;
  assign trap        = (r_state == S_TRAP);
  assign trap_cause  = r_cause;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: random and directed instructions,
// expected retire/trap records queued by stimulus, checked by a monitor.
module tb_core_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] instruction;
  logic        dmem_req, dmem_ack = 1'b0;
  logic        RF_wen = 1'b0, DM_wen = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        RF_wen_q, DM_wen_q, retire, trap;
  logic [31:0] pc, instret;
  logic [1:0]  trap_cause;

  core_sequencer #(
    .RESET_PC   (RPC),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .dmem_req     (dmem_req),
    .dmem_ack     (dmem_ack),
    .RF_wen       (RF_wen),
    .DM_wen       (DM_wen),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .RF_wen_q     (RF_wen_q),
    .DM_wen_q     (DM_wen_q),
    .pc           (pc),
    .retire       (retire),
    .instret      (instret),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_trap;
    logic [1:0]  cause;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] ir_now;
    logic [31:0] ir_next;
    bit          rf;
    int          cyc;
    int          mcyc;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_pc = RPC;
  logic [31:0] m_instret = '0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic fail_to(input string nm);
    total++;
    bad++;
    $display("FAIL %s act=no_event exp=event", nm);
  endtask

  function automatic bit legal(input logic [6:0] op);
    case (op)
      7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h33,
      7'h13, 7'h37, 7'h17, 7'h73, 7'h0f: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // Memory responder: ack on the (wn+1)-th cycle req is seen.
  task automatic serve(input bit is_i, input int wn,
                       input logic [31:0] w);
    int seen = 0;
    for (int t = 0; t < 40; t++) begin
      if (is_i ? imem_req : dmem_req) begin
        if (seen == wn) begin
          if (is_i) begin
            imem_ack   = 1'b1;
            imem_rdata = w;
          end else begin
            dmem_ack = 1'b1;
          end
          @(negedge clk);
          imem_ack = 1'b0;
          dmem_ack = 1'b0;
          return;
        end
        seen++;
      end
      @(negedge clk);
    end
    fail_to(is_i ? "imem_ack_wait" : "dmem_ack_wait");
  endtask

  // Called at the first FETCH cycle of the instruction.
  task automatic run_instr(input logic [31:0] w,
                           input int fw, input int mw,
                           input bit rf, input bit dm,
                           input bit tk, input logic [31:0] tg);
    exp_t e;
    bit   isl, ism, mis, done;
    int   c, mc;
    isl = legal(w[6:0]);
    ism = isl && (w[6:0] == 7'h03 || w[6:0] == 7'h23);
    mis = isl && tk && (tg[1:0] != 2'b00);
    mc  = ism ? mw + 1 : 0;
    c   = cyc;
    RF_wen        = rf;
    DM_wen        = dm;
    branch_taken  = tk;
    branch_target = tg;
    e.instr  = w;
    e.pc     = m_pc;
    e.ir_now = m_instret;
    e.rf     = rf;
    e.mcyc   = mc;
    e.is_trap = 1'b0;
    e.cause  = 2'd0;
    e.pc_next = m_pc;
    e.ir_next = m_instret;
    if (!isl) begin
      e.is_trap = 1'b1;
      e.cause   = 2'd1;
      e.cyc     = c + fw + 2;
    end else if (mis) begin
      e.is_trap = 1'b1;
      e.cause   = 2'd2;
      e.cyc     = c + fw + 4 + mc;
    end else begin
      e.cyc     = c + fw + 3 + mc;
      e.pc_next = tk ? tg : m_pc + 32'd4;
      e.ir_next = m_instret + 32'd1;
      m_pc      = e.pc_next;
      m_instret = e.ir_next;
    end
    exp_q.push_back(e);
    serve(1'b1, fw, w);
    if (ism) serve(1'b0, mw, '0);
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      if (retire || trap) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) fail_to("instr_complete");
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    RF_wen = 1'b0;
    DM_wen = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_imem_req", 32'(imem_req), '0);
    chk("rst_dmem_req", 32'(dmem_req), '0);
    chk("rst_retire", 32'(retire), '0);
    rst_n = 1'b1;
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_instret", instret, '0);
    chk("rst_trap", 32'(trap), '0);
    chk("rst_cause", 32'(trap_cause), '0);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_fetch_req", 32'(imem_req), 32'd1);
    chk("rst_fetch_addr", imem_addr, RPC);
    m_pc      = RPC;
    m_instret = '0;
  endtask

  // Monitor: pops one record per retire or trap entry.
  exp_t pexp;
  bit   pend = 1'b0;
  bit   tseen = 1'b0;
  int   mcnt = 0;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      pend  = 1'b0;
      tseen = 1'b0;
      mcnt  = 0;
    end else begin
      if (pend) begin
        chk("pc_next", pc, pexp.pc_next);
        chk("instret_next", instret, pexp.ir_next);
        pend = 1'b0;
      end
      if (dmem_req) begin
        mcnt++;
        chk("dm_wen_q_mem", 32'(DM_wen_q), 32'(DM_wen));
      end else begin
        chk("dm_wen_q_idle", 32'(DM_wen_q), '0);
      end
      if (!retire) chk("rf_wen_q_idle", 32'(RF_wen_q), '0);
      if (trap) begin
        chk("trap_imem_req", 32'(imem_req), '0);
        chk("trap_dmem_req", 32'(dmem_req), '0);
      end
      if (retire) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_retire act=%h exp=none", pc);
        end else begin
          e = exp_q.pop_front();
          chk("retire_kind", 32'(retire), 32'(!e.is_trap));
          chk("retire_cycle", 32'(cyc), 32'(e.cyc));
          chk("retire_pc", pc, e.pc);
          chk("retire_instret", instret, e.ir_now);
          chk("retire_instr", instruction, e.instr);
          chk("rf_wen_q_wb", 32'(RF_wen_q), 32'(e.rf));
          chk("dmem_req_cycles", 32'(mcnt), 32'(e.mcyc));
          pexp = e;
          pend = 1'b1;
        end
        mcnt = 0;
      end
      if (trap && !tseen) begin
        tseen = 1'b1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_trap act=%0d exp=none",
                   trap_cause);
        end else begin
          e = exp_q.pop_front();
          chk("trap_kind", 32'(trap), 32'(e.is_trap));
          chk("trap_cause", 32'(trap_cause), 32'(e.cause));
          chk("trap_cycle", 32'(cyc), 32'(e.cyc));
          chk("trap_pc", pc, e.pc);
          chk("trap_instret", instret, e.ir_now);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench timeout");
  end

  logic [6:0] ops[11] = '{7'h03, 7'h23, 7'h63, 7'h6f,
                          7'h67, 7'h33, 7'h13, 7'h37,
                          7'h17, 7'h73, 7'h0f};

  initial begin
    exp_t        et;
    logic [31:0] rw, rt;
    bit          got;
    do_reset();
    // ADDI, LW (3 waits), SW, taken BEQ
    run_instr(32'h0050_0093, 0, 0, 1'b1, 1'b0, 1'b0, '0);
    run_instr(32'h0000_2083, 0, 3, 1'b1, 1'b0, 1'b0, '0);
    run_instr(32'h0010_2023, 1, 2, 1'b0, 1'b1, 1'b0, '0);
    run_instr(32'h0000_0063, 0, 0, 1'b0, 1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 150; i++) begin
      rw = $urandom();
      rt = $urandom();
      rw[6:0] = ops[$urandom_range(0, 10)];
      rt[1:0] = 2'b00;
      run_instr(rw, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0), rt);
    end
    // misaligned taken target
    run_instr(32'h0000_0063, 0, 0, 1'b1, 1'b0, 1'b1, m_pc + 32'h42);

    do_reset();
    run_instr(32'hFFFF_FFFF, 1, 0, 1'b1, 1'b1, 1'b0, '0);
    repeat (20) @(negedge clk);

    // fetch never acked
    do_reset();
    et.is_trap = 1'b1;
    et.cause   = 2'd3;
    et.instr   = 32'h0000_0013;
    et.pc      = m_pc;
    et.pc_next = m_pc;
    et.ir_now  = m_instret;
    et.ir_next = m_instret;
    et.rf      = 1'b0;
    et.cyc     = cyc + TMO;
    et.mcyc    = 0;
    exp_q.push_back(et);
    got = 1'b0;
    for (int t = 0; t < 12 && !got; t++) begin
      @(negedge clk);
      if (trap) got = 1'b1;
    end
    if (!got) fail_to("timeout_trap");
    repeat (5) @(negedge clk);

    // ack on the last allowed cycle, then mid-MEM reset
    do_reset();
    run_instr(32'h0050_0093, TMO - 1, 0, 1'b1, 1'b0, 1'b0, '0);
    run_instr(32'h0000_2083, 0, TMO - 1, 1'b1, 1'b0, 1'b0, '0);
    run_instr(32'h0050_0093, 2, 0, 1'b1, 1'b0, 1'b0, '0);
    RF_wen = 1'b1;
    DM_wen = 1'b1;
    branch_taken = 1'b0;
    serve(1'b1, 0, 32'h0000_2083);
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      if (dmem_req) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) fail_to("mid_mem_req");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_drops_dmem_req", 32'(dmem_req), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_pc", pc, RPC);
    chk("midrst_instret", instret, '0);
    chk("midrst_dmem_req", 32'(dmem_req), '0);
    chk("midrst_imem_req", 32'(imem_req), 32'd1);
    m_pc      = RPC;
    m_instret = '0;

    // instret wrap
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    #1;
    chk("instret_preset", instret, 32'hFFFF_FFFF);
    m_instret = 32'hFFFF_FFFF;
    run_instr(32'h0050_0093, 0, 0, 1'b1, 1'b0, 1'b0, '0);
    run_instr(32'h0000_2083, 1, 1, 1'b1, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    chk("exp_queue_empty", 32'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle sequencer for the single-issue RV32I core.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB.
- Owns the PC, runs the valid/ack handshakes on the instruction and data memory ports, and latches the instruction word fed to ControlUnit.
- Gates ControlUnit's RF_wen/DM_wen so architectural state changes only in the correct phase.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 255, max cycles a req may wait for ack before trap; 0 disables the watchdog.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  fetch data valid
- imem_rdata  in  32  fetched word
- instruction  out  32  latched instruction to ControlUnit
- dmem_req  out  1  data access request (load/store)
- dmem_ack  in  1  data access complete
- RF_wen  in  1  ControlUnit register write enable (raw)
- DM_wen  in  1  ControlUnit data memory write enable (raw)
- branch_taken  in  1  ControlUnit/ALU branch or jump decision
- branch_target  in  32  datapath next-PC for taken branch/jump
- RF_wen_q  out  1  qualified RF write enable
- DM_wen_q  out  1  qualified DM write enable
- pc  out  32  current PC
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  32  retired-instruction count
- trap  out  1  sticky fault flag
- trap_cause  out  2  0 none, 1 illegal opcode, 2 misaligned target, 3 bus timeout

Behaviour:
- Clock is clk. Reset is rst_n: synchronous, active-low. It is sampled only on the rising edge of clk.
- Reset values:
  - state = S_FETCH, pc = RESET_PC, instruction = 32'h0000_0013 (NOP).
  - instret = 0, trap = 0, trap_cause = 0.
  - All req, wen_q and retire outputs = 0.
- States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP.
- S_FETCH:
  - imem_req = 1 combinationally, imem_addr = pc.
  - On imem_ack: latch imem_rdata into instruction, go to S_DECODE.
  - Zero-wait ack in the first req cycle is legal.
- S_DECODE, one cycle:
  - If opcode (instruction[6:0]) is not a supported RV32I opcode: trap_cause = 1, go to S_TRAP.
  - Otherwise go to S_EXEC.
- S_EXEC, one cycle:
  - Loads and stores go to S_MEM; all other instructions go to S_WB.
- S_MEM:
  - dmem_req = 1; DM_wen_q = DM_wen for every cycle req is high.
  - On dmem_ack go to S_WB.
- S_WB, one cycle:
  - RF_wen_q = RF_wen, retire = 1, instret += 1 (wraps 32'hFFFF_FFFF -> 0).
  - pc <= branch_taken ? branch_target : pc + 4 (pc + 4 wraps modulo 2^32).
  - Go to S_FETCH.
  - If branch_taken and branch_target[1:0] != 0: no pc update, no retire, no RF write, trap_cause = 2, go to S_TRAP.
- Latency with zero-wait memories: ALU/branch instruction = 4 cycles; load/store = 5 cycles.
- Outside the phases above, RF_wen_q and DM_wen_q are held 0.
- Handshake rules:
  - req stays high until ack is sampled high, then deasserts the next cycle.
  - An ack with req low is ignored.
  - Only one outstanding transaction at a time.
- Watchdog (MEM_TIMEOUT != 0):
  - Counter clears on entry to S_FETCH or S_MEM and increments every cycle req is high without ack.
  - When the count reaches MEM_TIMEOUT: trap_cause = 3, go to S_TRAP.
  - An ack arriving in the same cycle as the timeout wins; no trap.
- S_TRAP:
  - All reqs and wen_q are 0; pc and instret are frozen; trap = 1.
  - Exit only via reset.
- Reset mid-transaction: the FSM returns to S_FETCH and the req drops in the reset cycle. Memories abort on rst_n. A stale ack arriving after reset during S_FETCH is accepted as the fetch response, so memories must not hold an ack across reset.
- ECALL/EBREAK retire as NOPs.

Decomposition:
- Shared core_pkg (alongside definitions.sv):
  - seq_state_t enum.
  - trap_cause_t enum.
  - RV32I opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_FENCE).
  - NOP constant.
- One sub-module, bus_watchdog:
  - Inputs: clk, rst_n, start, req, ack.
  - Output: timeout.
  - Parameter: MEM_TIMEOUT.
  - Instantiated once and shared by the FETCH and MEM phases.

Test Plan:
- ADDI x1,x0,5 (32'h0050_0093) at pc 0 with zero-wait imem -> retire at cycle 4, RF_wen_q = 1 only in S_WB, pc = 4, instret = 1.
- LW with dmem_ack delayed 3 cycles -> dmem_req high exactly 4 cycles, retire at cycle 8, DM_wen_q = 0 throughout.
- SW -> DM_wen_q = 1 only while dmem_req is high, RF_wen_q = 0; BEQ with branch_taken = 1 and target 32'h40 -> pc = 32'h40; same with target 32'h42 -> trap_cause = 2, pc unchanged, no retire.
- Illegal opcode (32'hFFFF_FFFF) -> S_TRAP after DECODE, trap_cause = 1, imem_req stays 0 for 20 cycles.
- MEM_TIMEOUT = 4 with imem_ack never asserted -> trap_cause = 3 after 4 req cycles; repeat with ack on cycle 4 -> no trap.
- rst_n low for 1 cycle while in S_MEM -> next cycle state S_FETCH, pc = RESET_PC, instret = 0, dmem_req = 0; instret preset near wrap -> rolls 32'hFFFF_FFFF -> 0.
